motor_ramp_sched: RTL

//  APB3 slave that sequences the two drive motors: accepts target duty/direction per side,

---
 rtl/motor_ramp_sched.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched: APB3 dual H-bridge duty sequencer with ramping,
// reversal coast dwell, emergency brake and glitch-free PWM.
module motor_ramp_side #(
  parameter int PWM_PERIOD  = 1000,
  parameter int DWELL_TICKS = 4,
  parameter int DW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          enable,
  input  logic          estop,
  input  logic          tgt_dir,
  input  logic [DW-1:0] tgt_duty,
  input  logic [7:0]    step,
  input  logic [DW-1:0] pwm_cnt,
  input  logic          pwm_wrap,
  output logic [2:0]    state,
  output logic [DW-1:0] cur,
  output logic [1:0]    pins,
  output logic          pwm
);
  localparam int DCW = $clog2(DWELL_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    RAMP_DN = 3'd2,
    DWELL   = 3'd3,
    BRAKE   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  cur_q, cur_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic           dir_q, dir_d;
  logic [DCW-1:0] dwell_q, dwell_d;
  logic [DW-1:0]  step_w, diff, mv, dn;

  assign step_w = DW'(step);
  assign diff   = (tgt_duty > cur_q) ? tgt_duty - cur_q : cur_q - tgt_duty;
  assign mv     = (step_w < diff) ? step_w : diff;
  assign dn     = (step_w < cur_q) ? step_w : cur_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    duty_d  = pwm_wrap ? cur_q : duty_q;
    // estop is not tick-gated: brake wins from any state
    if (estop) begin
      state_d = BRAKE;
      cur_d   = '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          cur_d = '0;
          if (enable && tgt_duty != '0) begin
            dir_d   = tgt_dir;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!enable || tgt_dir != dir_q)
            state_d = RAMP_DN;
          else if (cur_q == '0 && tgt_duty == '0)
            state_d = IDLE;
          else if (tgt_duty > cur_q)
            cur_d = cur_q + mv;
          else
            cur_d = cur_q - mv;
        end
        RAMP_DN: begin
          cur_d = cur_q - dn;
          if (cur_q == dn) begin
            state_d = DWELL;
            dwell_d = '0;
          end
        end
        DWELL: begin
          if (dwell_q == DCW'(DWELL_TICKS - 1))
            state_d = IDLE;
          else
            dwell_d = dwell_q + DCW'(1);
        end
        BRAKE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pins = 2'b00;
    unique case (state_q)
      RUN, RAMP_DN: pins = dir_q ? 2'b01 : 2'b10;
      BRAKE:        pins = 2'b11;
      default:      pins = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
    end
  end

  assign state = state_q;
  assign cur   = cur_q;
  assign pwm   = pwm_cnt < duty_q;
endmodule

module motor_ramp_sched #(
  parameter int PWM_PERIOD  = 1000,
  parameter int TICK_DIV    = 50000,
  parameter int DWELL_TICKS = 4,
  parameter int DW          = 10
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] PRDATA,
  output logic        pwmLeft,
  output logic        pwmRight,
  output logic [3:0]  inputsAB
);
  localparam int TW = $clog2(TICK_DIV + 1);

  logic [DW-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic          dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic [7:0]    step_q, step_d;
  logic          en_q, en_d, estop_q, estop_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          tick, pwm_wrap;
  logic [2:0]    idx, st_l, st_r;
  logic          access, wr, bad;
  logic [DW-1:0] duty_w, cur_l, cur_r;
  logic [1:0]    pins_l, pins_r;
  logic          unused;

  assign tick     = tick_cnt_q == TW'(TICK_DIV - 1);
  assign pwm_wrap = pwm_cnt_q == DW'(PWM_PERIOD - 1);
  assign idx      = PADDR[4:2];
  assign access   = PSEL & PENABLE;
  assign wr       = access & PWRITE;
  assign bad      = (idx > 3'd4) || (PWRITE && idx == 3'd4);
  assign PSLVERR  = access & bad;
  assign PREADY   = 1'b1;
  assign duty_w   = (PWDATA[15:0] > 16'(PWM_PERIOD))
                  ? DW'(PWM_PERIOD) : PWDATA[DW-1:0];
  assign unused   = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:17]};

  always_comb begin
    tgt_l_d    = tgt_l_q;
    tgt_r_d    = tgt_r_q;
    dir_l_d    = dir_l_q;
    dir_r_d    = dir_r_q;
    step_d     = step_q;
    en_d       = en_q;
    estop_d    = estop_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + DW'(1);
    if (wr && !bad) begin
      unique case (idx)
        3'd0: begin tgt_l_d = duty_w; dir_l_d = PWDATA[16]; end
        3'd1: begin tgt_r_d = duty_w; dir_r_d = PWDATA[16]; end
        3'd2: step_d = PWDATA[7:0];
        3'd3: begin en_d = PWDATA[0]; estop_d = PWDATA[1]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      unique case (idx)
        3'd0: begin PRDATA[16] = dir_l_q; PRDATA[DW-1:0] = tgt_l_q; end
        3'd1: begin PRDATA[16] = dir_r_q; PRDATA[DW-1:0] = tgt_r_q; end
        3'd2: PRDATA[7:0] = step_q;
        3'd3: PRDATA[1:0] = {estop_q, en_q};
        3'd4: begin
          PRDATA[30:28]     = st_r;
          PRDATA[16 +: DW]  = cur_r;
          PRDATA[14:12]     = st_l;
          PRDATA[DW-1:0]    = cur_l;
        end
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tgt_l_q    <= '0;
      tgt_r_q    <= '0;
      dir_l_q    <= 1'b0;
      dir_r_q    <= 1'b0;
      step_q     <= '0;
      en_q       <= 1'b0;
      estop_q    <= 1'b0;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      dir_l_q    <= dir_l_d;
      dir_r_q    <= dir_r_d;
      step_q     <= step_d;
      en_q       <= en_d;
      estop_q    <= estop_d;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
    end
  end

  motor_ramp_side #(
    .PWM_PERIOD(PWM_PERIOD), .DWELL_TICKS(DWELL_TICKS), .DW(DW)
  ) u_left (
    .clk(PCLK), .rst(PRESET), .tick(tick), .enable(en_q),
    .estop(estop_q), .tgt_dir(dir_l_q), .tgt_duty(tgt_l_q),
    .step(step_q), .pwm_cnt(pwm_cnt_q), .pwm_wrap(pwm_wrap),
    .state(st_l), .cur(cur_l), .pins(pins_l), .pwm(pwmLeft)
  );

  motor_ramp_side #(
    .PWM_PERIOD(PWM_PERIOD), .DWELL_TICKS(DWELL_TICKS), .DW(DW)
  ) u_right (
    .clk(PCLK), .rst(PRESET), .tick(tick), .enable(en_q),
    .estop(estop_q), .tgt_dir(dir_r_q), .tgt_duty(tgt_r_q),
    .step(step_q), .pwm_cnt(pwm_cnt_q), .pwm_wrap(pwm_wrap),
    .state(st_r), .cur(cur_r), .pins(pins_r), .pwm(pwmRight)
  );

  assign inputsAB = {pins_r, pins_l};
endmodule
